add4_sequencer: RTL and testbench

Sequential controller that shares one WIDTH-bit adder across a packed vector of N_OPS operands. It captures the whole vector with a valid/ready handshake, then feeds one operand per cycle into the adder, accumulating the running total. It presents the widened sum on a valid/ready output port. It sits between the operand-packing stage (packed `[N_OPS-1:0][WIDTH-1:0]` buses) and downstream consumers of the sum, replacing a tree of N_OPS-1 adders.

---
 rtl/add4_sequencer_pkg.sv | 19 +
 rtl/add4_sequencer_if.sv | 36 +++
 rtl/add4_sequencer_adder_unit.sv | 14 +
 rtl/add4_sequencer.sv | 96 +++++++++
 tb/tb_add4_sequencer.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/add4_sequencer_pkg.sv
// Shared types and sizing helpers for the add4_sequencer shared-adder datapath.
// Holds the FSM encoding, default geometry and the result-width rule.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } seq_state_t;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_N_OPS = 4;

  // Wide enough that N_OPS maximal operands can never overflow the total.
  function automatic int sum_width(input int width, input int n);
    return width + $clog2(n);
  endfunction

endpackage

// File: rtl/add4_sequencer_if.sv
// Operand-vector input and sum output handshakes of add4_sequencer.
// The master side is the producer/consumer pair; the slave side is the sequencer.
interface add4_sequencer_if
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N_OPS = DEFAULT_N_OPS
);
  localparam int SUM_W = sum_width(WIDTH, N_OPS);

  logic                          in_valid;
  logic                          in_ready;
  logic [N_OPS-1:0][WIDTH-1:0]   number;
  logic                          out_valid;
  logic                          out_ready;
  logic [SUM_W-1:0]              sum;

  modport master (
    output in_valid,
    output number,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sum
  );

  modport slave (
    input  in_valid,
    input  number,
    input  out_ready,
    output in_ready,
    output out_valid,
    output sum
  );

endinterface

// File: rtl/add4_sequencer_adder_unit.sv
// The single shared adder: running total plus one zero-extended operand.
// Purely combinational; the sequencer registers the result.
module adder_unit #(
  parameter int WIDTH = 32,
  parameter int SUM_W = 34
) (
  input  logic [SUM_W-1:0] acc,
  input  logic [WIDTH-1:0] operand,
  output logic [SUM_W-1:0] result
);

  assign result = acc + {{(SUM_W - WIDTH){1'b0}}, operand};

endmodule

// File: rtl/add4_sequencer.sv
// Captures a packed operand vector, then sums it one element per cycle through
// one shared adder and offers the widened total on a valid/ready port.
module add4_sequencer
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N_OPS = DEFAULT_N_OPS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  add4_sequencer_if.slave             bus,
  output logic                        busy,
  output logic [$clog2(N_OPS)-1:0]    op_idx
);

  localparam int SUM_W = sum_width(WIDTH, N_OPS);
  localparam int IDX_W = $clog2(N_OPS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OPS - 1);

  seq_state_t                  state_q, state_d;
  logic [IDX_W-1:0]            op_idx_q, op_idx_d;
  logic [SUM_W-1:0]            acc_q, acc_d;
  logic [N_OPS-1:0][WIDTH-1:0] buf_q, buf_d;
  logic [SUM_W-1:0]            add_result;

  adder_unit #(
    .WIDTH (WIDTH),
    .SUM_W (SUM_W)
  ) u_adder (
    .acc     (acc_q),
    .operand (buf_q[op_idx_q]),
    .result  (add_result)
  );

  always_comb begin
    state_d  = state_q;
    op_idx_d = op_idx_q;
    acc_d    = acc_q;
    buf_d    = buf_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          buf_d    = bus.number;
          acc_d    = '0;
          op_idx_d = '0;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        acc_d = add_result;
        if (op_idx_q == LAST_IDX) begin
          op_idx_d = '0;
          state_d  = DONE;
        end else begin
          op_idx_d = op_idx_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over every state, including a concurrent output transfer.
    if (clear) begin
      state_d  = IDLE;
      op_idx_d = '0;
      acc_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      op_idx_q <= '0;
      acc_q    <= '0;
      buf_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_idx_q <= op_idx_d;
      acc_q    <= acc_d;
      buf_q    <= buf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = acc_q;
  assign busy          = (state_q != IDLE);
  assign op_idx        = op_idx_q;

endmodule

// File: tb/tb_add4_sequencer.sv
// Self-checking bench for add4_sequencer: directed cases plus random vectors,
// compared against a plain-arithmetic sum and the documented cycle timing.
module tb_add4_sequencer;

  localparam int WIDTH = 32;
  localparam int N_OPS = 4;

  typedef logic [N_OPS-1:0][WIDTH-1:0] vec_t;

  logic       clk;
  logic       reset;
  logic       clear;
  logic       busy;
  logic [1:0] op_idx;

  int total = 0;
  int bad   = 0;
  int txn_n = 0;

  add4_sequencer_if #(.WIDTH(WIDTH), .N_OPS(N_OPS)) bus ();

  add4_sequencer #(.WIDTH(WIDTH), .N_OPS(N_OPS)) dut (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .bus    (bus),
    .busy   (busy),
    .op_idx (op_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_sum(input vec_t v);
    logic [63:0] s;
    s = 64'd0;
    for (int i = 0; i < N_OPS; i++) s = s + 64'(v[i]);
    return s;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < N_OPS; i++) v[i] = $urandom;
    return v;
  endfunction

  // One full transaction; bp = cycles of held-off out_ready after out_valid rises.
  task automatic run_txn(input vec_t vec, input int bp, input bit scribble, output logic [63:0] got);
    int          n;
    logic [63:0] exp;
    logic [63:0] held;
    exp = model_sum(vec);
    @(negedge clk);
    n = 0;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("in_ready_wait", 64'(n < 20), 64'd1);
    bus.out_ready = (bp == 0);
    bus.number    = vec;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.number   = scribble ? '1 : rand_vec();
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!bus.out_valid && n <= N_OPS) begin
        check_eq("op_idx", 64'(op_idx), 64'(n - 1));
        check_eq("busy_accum", 64'(busy), 64'd1);
      end
    end while (!bus.out_valid && n < 20);
    check_eq("latency", 64'(n), 64'(N_OPS + 1));
    check_eq("sum", 64'(bus.sum), exp);
    held = 64'(bus.sum);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check_eq("hold_valid", 64'(bus.out_valid), 64'd1);
      check_eq("hold_sum", 64'(bus.sum), held);
      check_eq("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check_eq("post_valid", 64'(bus.out_valid), 64'd0);
    check_eq("post_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("post_busy", 64'(busy), 64'd0);
    got = held;
    txn_n++;
    $display("txn %0d bp=%0d sum=%0h exp=%0h", txn_n, bp, held, exp);
  endtask

  // Accept a vector and return positioned at the negedge inside the 2nd ACCUM cycle.
  task automatic start_and_reach_accum2(input vec_t vec);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.number    = vec;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [63:0] got;
    vec_t        v;
    int          seen;

    reset         = 1'b0;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.number    = '0;
    #2;
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_sum", 64'(bus.sum), 64'd0);
    check_eq("rst_op_idx", 64'(op_idx), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    v = {32'h0C011001, 32'hC1010001, 32'h0A010001, 32'h0A0B0B01};
    run_txn(v, 0, 1'b0, got);
    check_eq("basic_const", got, 64'h0E10E1B04);

    v = {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    run_txn(v, 0, 1'b0, got);
    check_eq("max_const", got, 64'h3FFFFFFFC);

    run_txn(rand_vec(), 10, 1'b0, got);

    v = {32'h00000011, 32'h00000022, 32'h00000033, 32'h00000044};
    run_txn(v, 0, 1'b1, got);
    check_eq("isolation_const", got, 64'h0AA);

    // Abort on the second ACCUM cycle.
    start_and_reach_accum2(rand_vec());
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    @(negedge clk);
    check_eq("abort_in_ready", 64'(bus.in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid) seen++;
      @(negedge clk);
    end
    check_eq("abort_no_valid", 64'(seen), 64'd0);
    v = {32'd4, 32'd3, 32'd2, 32'd1};
    run_txn(v, 0, 1'b0, got);
    check_eq("after_abort", got, 64'd10);

    // Asynchronous reset between edges during ACCUM.
    start_and_reach_accum2(rand_vec());
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_busy", 64'(busy), 64'd0);
    check_eq("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("arst_sum", 64'(bus.sum), 64'd0);
    check_eq("arst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    run_txn(rand_vec(), 0, 1'b0, got);
    run_txn(rand_vec(), 0, 1'b0, got);

    for (int t = 0; t < 12; t++) begin
      run_txn(rand_vec(), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
